axi_conf_regfile: RTL
=====================

# axi_conf_regfile

Parametrised AXI4 slave register file providing memory-mapped configuration and status registers for camera-pipeline IPs such as the DVP receiver, scaler and pixel DMA. It generalises the fixed three-register config block to REG_NUM registers. It adds byte-strobe writes, read-only status registers, ID echo on B/R, and SLVERR/DECERR responses. Independent write and read FSMs each allow one outstanding transaction.

## Interface
- BASE_ADDR, 32'h4000_0000: byte address of register 0; registers are spaced 4 bytes apart.
- REG_NUM, 8: number of 32-bit registers (1..64).
- DATA_W, 32: data width; fixed at 32.
- ADDR_W, 32: address width.
- MST_ID_W, 5: AXI ID width.
- RO_MASK, {REG_NUM{1'b0}}: bit i=1 makes register i read-only; reads return stat_i slice i.
- RST_VAL, {REG_NUM*DATA_W{1'b0}}: reset value of each RW register, packed with register 0 at the LSB.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- s_awid_i / s_awaddr_i / s_awvalid_i  in  MST_ID_W / ADDR_W / 1  write address
- s_awready_o  out  1
- s_wdata_i / s_wstrb_i / s_wvalid_i  in  DATA_W / DATA_W/8 / 1  write data
- s_wready_o  out  1
- s_bid_o / s_bresp_o / s_bvalid_o  out  MST_ID_W / 2 / 1  write response
- s_bready_i  in  1
- s_arid_i / s_araddr_i / s_arvalid_i  in  MST_ID_W / ADDR_W / 1  read address
- s_arready_o  out  1
- s_rid_o / s_rdata_o / s_rresp_o / s_rvalid_o  out  MST_ID_W / DATA_W / 2 / 1  read data
- s_rready_i  in  1
- conf_o  out  REG_NUM*DATA_W  current RW register contents, register i at bits [i*32+:32]
- stat_i  in  REG_NUM*DATA_W  status values for RO registers
- wr_pulse_o  out  REG_NUM  one-cycle pulse per register on a committed write

## Operation
- Address decode: offset = addr − BASE_ADDR.
  - hit when offset < 4*REG_NUM and offset[1:0]==0.
  - index = offset[2+:clog2(REG_NUM)].
- Write FSM, states WR_IDLE and WR_RESP:
  - In WR_IDLE, AW and W are captured independently into holding registers. awready = ~aw_held, wready = ~w_held.
  - The commit happens on the edge that completes the later of the two handshakes, or both if they occur in the same cycle. The FSM then moves to WR_RESP.
  - Commit on hit to an RW register: byte k of the register is written where s_wstrb_i[k]=1. wr_pulse_o[index]=1. bresp=OKAY 2'b00.
  - Commit on hit to an RO register: no write, no pulse, bresp=SLVERR 2'b10.
  - Commit on a miss: no write, bresp=DECERR 2'b11.
  - A write with all strobes 0 to an RW register gives OKAY and pulses wr_pulse_o, but changes no bits.
  - In WR_RESP: awready=wready=0. bvalid=1 with bid = captured awid, held stable until bready. Return to WR_IDLE on the B handshake.
- Read FSM, states RD_IDLE and RD_RESP:
  - In RD_IDLE: arready=1.
  - On the AR handshake, rdata/rresp/rid are registered and the FSM moves to RD_RESP.
  - Read data source:
    - RW register: conf value as it stands before any commit on the same edge.
    - RO register: stat_i sampled at the AR edge.
    - Miss: rdata 0, rresp DECERR.
  - In RD_RESP: arready=0. R outputs held stable until rready. Return to RD_IDLE on the R handshake.
- Read and write paths are fully independent. A same-cycle read and write to the same register returns the old value.

## Timing
- Reset values:
  - awready=wready=arready=1.
  - bvalid=rvalid=0; bid/bresp/rid/rdata/rresp=0.
  - wr_pulse_o=0.
  - conf_o=RST_VAL.
  - Both holding registers empty; FSMs in IDLE.
- Write latency:
  - AW and W handshakes in cycle 0 → conf_o updated, wr_pulse_o and bvalid asserted in cycle 1.
  - AW in cycle 0 and W in cycle 3 → update and bvalid in cycle 4.
- Read latency: AR handshake in cycle 0 → rvalid in cycle 1. With rready held high, back-to-back reads complete at one read every 2 cycles.
- wr_pulse_o is exactly one cycle wide per commit.
- Reset asserted mid-transaction aborts it: pending B/R are dropped, holding registers are cleared, and registers return to RST_VAL.

## Structure
- Package conf_regfile_pkg:
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
  - Write FSM state encoding: WR_IDLE, WR_RESP.
  - Read FSM state encoding: RD_IDLE, RD_RESP.
- Sub-module conf_addr_decode, combinational, parameters BASE_ADDR and REG_NUM. Outputs hit and index. Instantiated once for the write path and once for the read path.

## Test plan
- Reset, then AW=0x4000_0004 and W=0xDEAD_BEEF with wstrb=4'hF in the same cycle, bready=1 → in cycle 1, conf_o reg1=0xDEADBEEF, wr_pulse_o=2'b10 on bits [1:0], bresp=00, bid=awid.
- Write to reg1 with wstrb=4'b0101 and data 0x1122_3344, starting from 0xDEADBEEF → reg1=0xDE22BE44.
- AW to 0x4000_0100 with REG_NUM=8 → bresp=11, no register changes, no pulse. AR to the same address → rdata=0, rresp=11.
- RO_MASK bit 0 set, stat_i reg0=0x0000_00A5: read 0x4000_0000 → rdata=0xA5, rresp=00. Write to 0x4000_0000 → bresp=10.
- W sent 3 cycles before AW, with bready held low for 4 cycles → awready=wready stay 0 until the B handshake. bvalid and bid stay stable the whole time.
- Read and write to reg2 in the same cycle, old value 0x0, new value 0x55 → rdata=0x0. A following read returns 0x55.

Source files
------------

// File: rtl/conf_regfile_pkg.sv
// Shared response codes, FSM encodings and sizing helper for the AXI configuration register file.
package conf_regfile_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic {WR_IDLE, WR_RESP} wr_state_e;
    typedef enum logic {RD_IDLE, RD_RESP} rd_state_e;

    // A single-register file still needs a 1-bit index so the ports stay legal.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conf_addr_decode.sv
// Maps an AXI byte address onto a register index; hit only for aligned in-range addresses.
module conf_addr_decode
    import conf_regfile_pkg::*;
#(
    parameter int              ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h4000_0000,
    parameter int              REG_NUM   = 8,
    parameter int              IDX_W     = idx_width(REG_NUM)
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              hit,
    output logic [IDX_W-1:0]  index
);

    logic [ADDR_W-1:0] offset;

    // Addresses below BASE_ADDR wrap to huge offsets and therefore miss.
    assign offset = addr - BASE_ADDR;
    assign hit    = (offset < ADDR_W'(4 * REG_NUM)) && (offset[1:0] == 2'b00);
    assign index  = offset[2 +: IDX_W];

endmodule

// File: rtl/axi_conf_regfile.sv
// AXI4 slave register file: RW configuration registers with byte strobes, RO status registers,
// independent single-outstanding write and read channels.
module axi_conf_regfile
    import conf_regfile_pkg::*;
#(
    parameter logic [31:0]             BASE_ADDR = 32'h4000_0000,
    parameter int                      REG_NUM   = 8,
    parameter int                      DATA_W    = 32,
    parameter int                      ADDR_W    = 32,
    parameter int                      MST_ID_W  = 5,
    parameter logic [REG_NUM-1:0]        RO_MASK   = '0,
    parameter logic [REG_NUM*DATA_W-1:0] RST_VAL   = '0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [MST_ID_W-1:0]         s_awid_i,
    input  logic [ADDR_W-1:0]           s_awaddr_i,
    input  logic                        s_awvalid_i,
    output logic                        s_awready_o,
    input  logic [DATA_W-1:0]           s_wdata_i,
    input  logic [DATA_W/8-1:0]         s_wstrb_i,
    input  logic                        s_wvalid_i,
    output logic                        s_wready_o,
    output logic [MST_ID_W-1:0]         s_bid_o,
    output logic [1:0]                  s_bresp_o,
    output logic                        s_bvalid_o,
    input  logic                        s_bready_i,
    input  logic [MST_ID_W-1:0]         s_arid_i,
    input  logic [ADDR_W-1:0]           s_araddr_i,
    input  logic                        s_arvalid_i,
    output logic                        s_arready_o,
    output logic [MST_ID_W-1:0]         s_rid_o,
    output logic [DATA_W-1:0]           s_rdata_o,
    output logic [1:0]                  s_rresp_o,
    output logic                        s_rvalid_o,
    input  logic                        s_rready_i,
    output logic [REG_NUM*DATA_W-1:0]   conf_o,
    input  logic [REG_NUM*DATA_W-1:0]   stat_i,
    output logic [REG_NUM-1:0]          wr_pulse_o
);

    localparam int IDX_W  = idx_width(REG_NUM);
    localparam int STRB_W = DATA_W / 8;

    wr_state_e wr_state, wr_state_nxt;
    rd_state_e rd_state, rd_state_nxt;

    logic                      aw_held, w_held;
    logic [MST_ID_W-1:0]       awid_q;
    logic [ADDR_W-1:0]         awaddr_q;
    logic [DATA_W-1:0]         wdata_q;
    logic [STRB_W-1:0]         wstrb_q;

    logic                      aw_hs, w_hs, ar_hs, commit;
    logic [MST_ID_W-1:0]       wr_id;
    logic [ADDR_W-1:0]         wr_addr;
    logic [DATA_W-1:0]         wr_data;
    logic [STRB_W-1:0]         wr_strb;
    logic                      wr_hit, wr_ro, rd_hit;
    logic [IDX_W-1:0]          wr_idx, rd_idx;
    logic [1:0]                wr_resp;
    logic [DATA_W-1:0]         rd_word;
    logic                      rd_ro;

    logic [REG_NUM*DATA_W-1:0] conf_q;
    logic [REG_NUM-1:0]        wr_pulse_q;
    logic [MST_ID_W-1:0]       bid_q, rid_q;
    logic [1:0]                bresp_q, rresp_q;
    logic [DATA_W-1:0]         rdata_q;

    assign s_awready_o = (wr_state == WR_IDLE) && !aw_held;
    assign s_wready_o  = (wr_state == WR_IDLE) && !w_held;
    assign s_bvalid_o  = (wr_state == WR_RESP);
    assign s_arready_o = (rd_state == RD_IDLE);
    assign s_rvalid_o  = (rd_state == RD_RESP);

    assign aw_hs  = s_awvalid_i && s_awready_o;
    assign w_hs   = s_wvalid_i && s_wready_o;
    assign ar_hs  = s_arvalid_i && s_arready_o;
    assign commit = (wr_state == WR_IDLE) && (aw_held || aw_hs) && (w_held || w_hs);

    // The later half of the write pair arrives directly from the bus; the earlier one is held.
    assign wr_id   = aw_held ? awid_q   : s_awid_i;
    assign wr_addr = aw_held ? awaddr_q : s_awaddr_i;
    assign wr_data = w_held  ? wdata_q  : s_wdata_i;
    assign wr_strb = w_held  ? wstrb_q  : s_wstrb_i;

    conf_addr_decode #(
        .ADDR_W(ADDR_W), .BASE_ADDR(ADDR_W'(BASE_ADDR)), .REG_NUM(REG_NUM), .IDX_W(IDX_W)
    ) u_wr_dec (
        .addr(wr_addr), .hit(wr_hit), .index(wr_idx)
    );

    conf_addr_decode #(
        .ADDR_W(ADDR_W), .BASE_ADDR(ADDR_W'(BASE_ADDR)), .REG_NUM(REG_NUM), .IDX_W(IDX_W)
    ) u_rd_dec (
        .addr(s_araddr_i), .hit(rd_hit), .index(rd_idx)
    );

    always_comb begin
        wr_ro = 1'b0;
        for (int i = 0; i < REG_NUM; i++) begin
            if (wr_idx == IDX_W'(i)) wr_ro = RO_MASK[i];
        end
        if (!wr_hit)    wr_resp = RESP_DECERR;
        else if (wr_ro) wr_resp = RESP_SLVERR;
        else            wr_resp = RESP_OKAY;
    end

    // RW reads see the register before any same-edge commit lands.
    always_comb begin
        rd_word = '0;
        rd_ro   = 1'b0;
        for (int i = 0; i < REG_NUM; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_ro   = RO_MASK[i];
                rd_word = RO_MASK[i] ? stat_i[i*DATA_W +: DATA_W] : conf_q[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        wr_state_nxt = wr_state;
        case (wr_state)
            WR_IDLE: if (commit) wr_state_nxt = WR_RESP;
            WR_RESP: if (s_bready_i) wr_state_nxt = WR_IDLE;
            default: wr_state_nxt = WR_IDLE;
        endcase
    end

    always_comb begin
        rd_state_nxt = rd_state;
        case (rd_state)
            RD_IDLE: if (ar_hs) rd_state_nxt = RD_RESP;
            RD_RESP: if (s_rready_i) rd_state_nxt = RD_IDLE;
            default: rd_state_nxt = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state <= WR_IDLE;
            rd_state <= RD_IDLE;
        end else begin
            wr_state <= wr_state_nxt;
            rd_state <= rd_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            awid_q   <= '0;
            awaddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
        end else if (commit) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
        end else begin
            if (aw_hs) begin
                aw_held  <= 1'b1;
                awid_q   <= s_awid_i;
                awaddr_q <= s_awaddr_i;
            end
            if (w_hs) begin
                w_held  <= 1'b1;
                wdata_q <= s_wdata_i;
                wstrb_q <= s_wstrb_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conf_q     <= RST_VAL;
            wr_pulse_q <= '0;
            bid_q      <= '0;
            bresp_q    <= RESP_OKAY;
        end else begin
            wr_pulse_q <= '0;
            if (commit) begin
                bid_q   <= wr_id;
                bresp_q <= wr_resp;
                for (int i = 0; i < REG_NUM; i++) begin
                    if (wr_hit && !RO_MASK[i] && (wr_idx == IDX_W'(i))) begin
                        wr_pulse_q[i] <= 1'b1;
                        for (int k = 0; k < STRB_W; k++) begin
                            if (wr_strb[k]) conf_q[i*DATA_W + k*8 +: 8] <= wr_data[k*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rid_q   <= '0;
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else if (ar_hs) begin
            rid_q   <= s_arid_i;
            rdata_q <= rd_hit ? rd_word : '0;
            rresp_q <= rd_hit ? RESP_OKAY : RESP_DECERR;
        end
    end

    assign conf_o     = conf_q;
    assign wr_pulse_o = wr_pulse_q;
    assign s_bid_o    = bid_q;
    assign s_bresp_o  = bresp_q;
    assign s_rid_o    = rid_q;
    assign s_rdata_o  = rdata_q;
    assign s_rresp_o  = rresp_q;

endmodule
